audio_clip_sequencer: RTL and testbench
=======================================

Name: audio_clip_sequencer

Overview:
Parametrised sample-address sequencer for the audio playback path.
- Waits for the codec init handshake to finish.
- Plays one clip at a time from sample ROM, between a start address and an end address that are latched at request time.
- Steps the address at a programmable divider rate, gated by the codec's sample-consumed strobe.
- Supports one-shot and loop modes, retrigger, stop and end-of-clip notification, so game logic can fire sound effects on demand.

Parameters:
ADDR_W, 17, width of the ROM sample address.
DIV_W, 16, width of the rate divider and its internal counter.
SILENT_ADDR, 0, address driven whenever no clip is playing (ROM word holding silence).

Ports:
Clk  in  1  system clock.
Reset  in  1  synchronous, active-high reset.
INIT_FINISH  in  1  codec initialisation complete (level).
INIT  out  1  codec init request.
play_req  in  1  single-cycle request to start a clip.
clip_start  in  ADDR_W  first sample address; sampled only with play_req.
clip_end  in  ADDR_W  last sample address, inclusive; sampled only with play_req.
loop_en  in  1  1 = loop the clip, 0 = one-shot; sampled only with play_req.
divider  in  DIV_W  sample period minus one, in Clk cycles; sampled only with play_req.
stop_req  in  1  single-cycle request to abort playback.
data_over  in  1  codec has consumed the current sample (level).
Add  out  ADDR_W  current ROM sample address (registered).
busy  out  1  clip playing.
clip_done  out  1  one-cycle pulse at natural end of a one-shot clip.
req_err  out  1  one-cycle pulse when play_req is rejected.

Behaviour:
Reset values:
- State WAIT_INIT; Add = SILENT_ADDR.
- busy, clip_done, req_err, INIT = 0.
- Internal counter and pending flag = 0.
- All latched clip registers = 0.

Outputs:
- All outputs are registered.
- INIT goes to 1 on the first cycle after reset deasserts and stays 1 until the next reset.

States:
- WAIT_INIT: Add = SILENT_ADDR. Go to IDLE on the edge where INIT_FINISH = 1. play_req and stop_req are ignored (no req_err).
- IDLE: Add = SILENT_ADDR, busy = 0.
  - play_req with clip_end >= clip_start: latch start, end, loop_en and divider; Add <= clip_start; counter <= 0; pending <= 0; busy <= 1; go to PLAY. Add and busy are visible 1 cycle after play_req.
  - play_req with clip_end < clip_start: stay in IDLE; req_err pulses for 1 cycle on the next cycle.
- PLAY:
  - Counter: increments every cycle. When counter == latched divider, tick = 1 and counter <= 0. The sample period is therefore divider+1 cycles; divider = 0 gives a tick every cycle.
  - Advance condition: (tick or pending) and data_over.
  - Tick without data_over sets pending. A further tick while pending is already set is absorbed: there is no double advance.
  - On advance, pending <= 0 and:
    - Add != end: Add <= Add + 1.
    - Add == end and loop = 1: Add <= start; busy stays 1; no clip_done.
    - Add == end and loop = 0: Add <= SILENT_ADDR; busy <= 0; clip_done pulses 1 cycle; go to IDLE.
  - stop_req: go to IDLE; Add <= SILENT_ADDR; busy <= 0; no clip_done; pending cleared.
  - play_req without stop_req (retrigger): same as the IDLE accept path, including req_err on an invalid range. An invalid retrigger leaves the current clip playing untouched.
  - stop_req and play_req in the same cycle: stop wins; play_req is dropped.
  - stop_req and the final advance of a one-shot clip in the same cycle: stop wins; no clip_done.
- Single-sample clip (start == end): one-shot plays one sample then ends; loop mode holds Add constant.

Arithmetic and width:
- Add + 1 is ADDR_W wide.
- end at the maximum address is legal; no wrap past end is possible because end is compared before incrementing.

Reset:
- Reset asserted in any state, including mid-clip, returns to WAIT_INIT with reset values.
- INIT_FINISH must be seen again before any playback.

Test Plan:
1. Reset, INIT_FINISH low for 5 cycles then high -> INIT = 1 from cycle 1; state leaves WAIT_INIT only after INIT_FINISH; Add = 0 throughout.
2. IDLE, play_req with start = 100, end = 103, loop = 0, divider = 3, data_over held 1 -> Add = 100 one cycle later, then 101, 102, 103 every 4 cycles; 4 cycles after 103, Add = 0, busy = 0, and clip_done high for exactly 1 cycle.
3. Same clip with loop = 1 -> Add sequence 100, 101, 102, 103, 100, 101, ...; busy stays 1; clip_done never pulses; stop_req mid-stream -> Add = 0 and busy = 0 the next cycle, with no clip_done.
4. divider = 1, data_over low for 6 cycles after a tick, then high for 1 cycle -> exactly one advance, occurring on the data_over cycle; Add increments by 1 only.
5. play_req with start = 50, end = 40 -> req_err pulses 1 cycle; busy stays 0; Add stays 0. Retrigger during PLAY with start = 200, end = 210 -> Add = 200 next cycle and counter restarts. play_req and stop_req together -> IDLE.
6. Reset asserted mid-clip at Add = 102 -> next cycle Add = 0, busy = 0, state WAIT_INIT; play_req is ignored until INIT_FINISH is seen again.

Source files
------------

// File: rtl/audio_clip_sequencer.sv
// Sample-address sequencer: waits for codec init, then plays one ROM clip at a
// time at a programmable rate, gated by the codec's sample-consumed strobe.
module audio_clip_sequencer #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DIV_W  = 16,
  parameter logic [ADDR_W-1:0] SILENT_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              INIT_FINISH,
  output logic              INIT,
  input  logic              play_req,
  input  logic [ADDR_W-1:0] clip_start,
  input  logic [ADDR_W-1:0] clip_end,
  input  logic              loop_en,
  input  logic [DIV_W-1:0]  divider,
  input  logic              stop_req,
  input  logic              data_over,
  output logic [ADDR_W-1:0] Add,
  output logic              busy,
  output logic              clip_done,
  output logic              req_err
);

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    PLAY      = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [ADDR_W-1:0]  add_q, add_n;
  logic [ADDR_W-1:0]  start_q, start_n;
  logic [ADDR_W-1:0]  end_q, end_n;
  logic [DIV_W-1:0]   div_q, div_n;
  logic [DIV_W-1:0]   cnt_q, cnt_n;
  logic               loop_q, loop_n;
  logic               pending_q, pending_n;
  logic               busy_n, done_n, err_n;

  logic               req_valid_c;
  logic               tick_c;
  logic               advance_c;

  assign req_valid_c = (clip_end >= clip_start);
  assign tick_c      = (cnt_q == div_q);
  assign advance_c   = (tick_c || pending_q) && data_over;

  // Next-state and next-output computation for every register
  always_comb begin
    state_n   = state_q;
    add_n     = add_q;
    start_n   = start_q;
    end_n     = end_q;
    div_n     = div_q;
    cnt_n     = cnt_q;
    loop_n    = loop_q;
    pending_n = pending_q;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = 1'b0;

    unique case (state_q)
      WAIT_INIT: begin
        add_n  = SILENT_ADDR;
        busy_n = 1'b0;
        if (INIT_FINISH) state_n = IDLE;
      end

      IDLE: begin
        add_n  = SILENT_ADDR;
        busy_n = 1'b0;
        cnt_n  = '0;
      end

      PLAY: begin
        // Rate divider and pending-tick bookkeeping; extra ticks are absorbed
        cnt_n = tick_c ? '0 : cnt_q + DIV_W'(1);
        if (advance_c) begin
          pending_n = 1'b0;
          if (add_q != end_q) begin
            add_n = add_q + ADDR_W'(1);
          end else if (loop_q) begin
            add_n = start_q;
          end else begin
            add_n   = SILENT_ADDR;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else if (tick_c) begin
          pending_n = 1'b1;
        end
      end

      default: state_n = WAIT_INIT;
    endcase

    // Play request from IDLE or as a retrigger; an invalid range leaves playback untouched
    if ((state_q == IDLE || state_q == PLAY) && play_req && !stop_req) begin
      if (req_valid_c) begin
        start_n   = clip_start;
        end_n     = clip_end;
        loop_n    = loop_en;
        div_n     = divider;
        add_n     = clip_start;
        cnt_n     = '0;
        pending_n = 1'b0;
        busy_n    = 1'b1;
        done_n    = 1'b0;
        state_n   = PLAY;
      end else begin
        err_n = 1'b1;
      end
    end

    // Stop overrides everything, including a final one-shot advance
    if (state_q == PLAY && stop_req) begin
      state_n   = IDLE;
      add_n     = SILENT_ADDR;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      pending_n = 1'b0;
      cnt_n     = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= WAIT_INIT;
      add_q     <= SILENT_ADDR;
      start_q   <= '0;
      end_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      loop_q    <= 1'b0;
      pending_q <= 1'b0;
      busy      <= 1'b0;
      clip_done <= 1'b0;
      req_err   <= 1'b0;
      INIT      <= 1'b0;
    end else begin
      state_q   <= state_n;
      add_q     <= add_n;
      start_q   <= start_n;
      end_q     <= end_n;
      div_q     <= div_n;
      cnt_q     <= cnt_n;
      loop_q    <= loop_n;
      pending_q <= pending_n;
      busy      <= busy_n;
      clip_done <= done_n;
      req_err   <= err_n;
      INIT      <= 1'b1;
    end
  end

  assign Add = add_q;

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Directed bench for audio_clip_sequencer with hand-computed expectations.
module tb_audio_clip_sequencer;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DIV_W  = 16;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              INIT_FINISH;
  logic              INIT;
  logic              play_req;
  logic [ADDR_W-1:0] clip_start;
  logic [ADDR_W-1:0] clip_end;
  logic              loop_en;
  logic [DIV_W-1:0]  divider;
  logic              stop_req;
  logic              data_over;
  logic [ADDR_W-1:0] Add;
  logic              busy;
  logic              clip_done;
  logic              req_err;

  int total = 0;
  int bad   = 0;

  audio_clip_sequencer #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .SILENT_ADDR('0)) dut (
    .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .INIT(INIT),
    .play_req(play_req), .clip_start(clip_start), .clip_end(clip_end),
    .loop_en(loop_en), .divider(divider), .stop_req(stop_req),
    .data_over(data_over), .Add(Add), .busy(busy), .clip_done(clip_done),
    .req_err(req_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int a, input logic b, input logic d);
    chk({tag, ".add"}, 32'(Add), 32'(a));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(clip_done), 32'(d));
  endtask

  task automatic request(input int s, input int e, input logic lp, input int dv);
    play_req   = 1'b1;
    clip_start = ADDR_W'(s);
    clip_end   = ADDR_W'(e);
    loop_en    = lp;
    divider    = DIV_W'(dv);
    step();
    play_req   = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; INIT_FINISH = 1'b0; play_req = 1'b0; clip_start = '0;
    clip_end = '0; loop_en = 1'b0; divider = '0; stop_req = 1'b0; data_over = 1'b0;

    // 1: reset and init handshake
    step(); step();
    expect_out("rst", 0, 1'b0, 1'b0);
    chk("rst.init", 32'(INIT), 32'd0);
    chk("rst.err", 32'(req_err), 32'd0);
    Reset = 1'b0;
    step();
    chk("init.high", 32'(INIT), 32'd1);
    // requests are ignored while waiting for init
    request(10, 20, 1'b0, 0);
    expect_out("wait.play", 0, 1'b0, 1'b0);
    request(50, 40, 1'b0, 0);
    chk("wait.noerr", 32'(req_err), 32'd0);
    step(); step();
    expect_out("wait.hold", 0, 1'b0, 1'b0);
    INIT_FINISH = 1'b1;
    step();
    chk("init.stays", 32'(INIT), 32'd1);

    // 2: one-shot clip, divider 3
    data_over = 1'b1;
    request(100, 103, 1'b0, 3);
    expect_out("os.c0", 100, 1'b1, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c < 16)       expect_out($sformatf("os.c%0d", c), 100 + c / 4, 1'b1, 1'b0);
      else if (c == 16) expect_out("os.end", 0, 1'b0, 1'b1);
      else              expect_out("os.after", 0, 1'b0, 1'b0);
    end

    // 3: looping clip, then stop mid-stream
    request(100, 103, 1'b1, 3);
    expect_out("lp.c0", 100, 1'b1, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      step();
      expect_out($sformatf("lp.c%0d", c), 100 + (c / 4) % 4, 1'b1, 1'b0);
    end
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    expect_out("lp.stop", 0, 1'b0, 1'b0);

    // 4: ticks while codec is not ready collapse into one advance
    data_over = 1'b0;
    request(300, 310, 1'b0, 1);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("pend.c%0d", c), 32'(Add), 32'd300);
    end
    data_over = 1'b1;
    step();
    data_over = 1'b0;
    chk("pend.adv", 32'(Add), 32'd301);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("pend.hold%0d", c), 32'(Add), 32'd301);
    end
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    expect_out("pend.stop", 0, 1'b0, 1'b0);

    // 5: invalid request, retrigger, invalid retrigger, play+stop together
    data_over = 1'b1;
    request(50, 40, 1'b0, 0);
    expect_out("err.idle", 0, 1'b0, 1'b0);
    chk("err.pulse", 32'(req_err), 32'd1);
    step();
    chk("err.clear", 32'(req_err), 32'd0);
    request(100, 103, 1'b1, 3);
    for (int c = 0; c < 5; c++) step();
    chk("rt.pre", 32'(Add), 32'd101);
    request(200, 210, 1'b0, 3);
    expect_out("rt.new", 200, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("rt.c%0d", c), 32'(Add), 32'd200);
    end
    step();
    chk("rt.adv", 32'(Add), 32'd201);
    request(50, 40, 1'b1, 0);
    chk("rt.err", 32'(req_err), 32'd1);
    expect_out("rt.keep", 201, 1'b1, 1'b0);
    step(); step();
    chk("rt.keep2", 32'(Add), 32'd201);
    step();
    chk("rt.cont", 32'(Add), 32'd202);
    stop_req = 1'b1;
    request(400, 410, 1'b0, 0);
    stop_req = 1'b0;
    expect_out("ps.stop", 0, 1'b0, 1'b0);
    chk("ps.noerr", 32'(req_err), 32'd0);
    step();
    expect_out("ps.idle", 0, 1'b0, 1'b0);

    // single-sample clips, and stop colliding with the final advance
    request(500, 500, 1'b0, 0);
    expect_out("ss.start", 500, 1'b1, 1'b0);
    step();
    expect_out("ss.end", 0, 1'b0, 1'b1);
    request(500, 500, 1'b0, 0);
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    expect_out("ss.stopwin", 0, 1'b0, 1'b0);
    request(500, 500, 1'b1, 0);
    step(); step(); step();
    expect_out("ss.loop", 500, 1'b1, 1'b0);
    // end at the maximum address
    request((1 << ADDR_W) - 2, (1 << ADDR_W) - 1, 1'b0, 0);
    step();
    chk("max.last", 32'(Add), 32'((1 << ADDR_W) - 1));
    step();
    expect_out("max.end", 0, 1'b0, 1'b1);

    // 6: reset mid-clip, then init must be seen again
    request(100, 103, 1'b0, 3);
    for (int c = 0; c < 8; c++) step();
    chk("mr.pre", 32'(Add), 32'd102);
    Reset = 1'b1;
    INIT_FINISH = 1'b0;
    step();
    Reset = 1'b0;
    expect_out("mr.rst", 0, 1'b0, 1'b0);
    chk("mr.init", 32'(INIT), 32'd0);
    request(100, 103, 1'b0, 3);
    expect_out("mr.ignored", 0, 1'b0, 1'b0);
    chk("mr.init1", 32'(INIT), 32'd1);
    INIT_FINISH = 1'b1;
    step();
    request(100, 103, 1'b0, 3);
    expect_out("mr.play", 100, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
